// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the eight mux requesters and the round-robin arbiter.
// The arbiter takes the slave view; the requester side (or a bench) takes the master view.
interface mux_rr_arbiter_if #(
    parameter int NREQ  = 8,
    parameter int SEL_W = 3
);
    logic [NREQ-1:0]  req;
    logic [SEL_W-1:0] sel;
    logic [NREQ-1:0]  grant;
    logic             valid;
    logic             switch_pulse;
    logic             timeout_pulse;

    modport master (
        output req,
        input  sel, grant, valid, switch_pulse, timeout_pulse
    );

    modport slave (
        input  req,
        output sel, grant, valid, switch_pulse, timeout_pulse
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner/hold arbiter driving the SEL input of the 16-bit 8:1 mux.
// Define MUX_ARB_TIMEOUT_EN to force rotation after MAX_HOLD consecutive grant cycles.
module mux_rr_arbiter #(
    parameter int NREQ     = 8,
    parameter int SEL_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input logic             clk,
    input logic             rst_n,
    mux_rr_arbiter_if.slave bus
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] lastOwner_q;
    logic [NREQ-1:0]  grant_q;
    logic             valid_q;
    logic             switch_q;
    logic             timeout_q;

    logic [SEL_W-1:0] winner;
    logic             anyReq;
    logic             ownerReq;
    logic             takeGrant;
    logic             goIdle;
    logic             forceRot;

    // Scan starts just past the last owner, so the previous owner always ranks lowest.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        winner = lastOwner_q;
        for (int k = 1; k <= NREQ; k++) begin
            idx = lastOwner_q + SEL_W'(k);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign anyReq   = |bus.req;
    assign ownerReq = bus.req[sel_q];

`ifdef MUX_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] holdCnt_q;

    assign forceRot = (state_q == OWNED) && ownerReq
                   && (holdCnt_q == HOLD_W'(MAX_HOLD - 1))
                   && (|(bus.req & ~grant_q));

    // Counts held cycles of the current owner; saturates when nobody else is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdCnt_q <= '0;
        end else if (takeGrant) begin
            holdCnt_q <= '0;
        end else if (state_q == OWNED && holdCnt_q != HOLD_W'(MAX_HOLD - 1)) begin
            holdCnt_q <= holdCnt_q + 1'b1;
        end
    end
`else
    logic unusedHoldCfg;
    assign unusedHoldCfg = ^{32'(MAX_HOLD), 32'(HOLD_W)};
    assign forceRot      = 1'b0;
`endif

    assign takeGrant = ((state_q == IDLE) && anyReq)
                    || ((state_q == OWNED) && !ownerReq && anyReq)
                    || forceRot;
    assign goIdle    = (state_q == OWNED) && !ownerReq && !anyReq;

    // last_owner tracks the newest grant; while OWNED it equals the owner, so release searches from owner+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            lastOwner_q <= '1;
            grant_q     <= '0;
            valid_q     <= 1'b0;
            switch_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            switch_q  <= 1'b0;
            timeout_q <= 1'b0;
            if (takeGrant) begin
                state_q     <= OWNED;
                sel_q       <= winner;
                lastOwner_q <= winner;
                grant_q     <= NREQ'(1) << winner;
                valid_q     <= 1'b1;
                switch_q    <= 1'b1;
                timeout_q   <= forceRot;
            end else if (goIdle) begin
                state_q <= IDLE;
                grant_q <= '0;
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.sel           = sel_q;
    assign bus.grant         = grant_q;
    assign bus.valid         = valid_q;
    assign bus.switch_pulse  = switch_q;
    assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, hold/release, full rotation, wrap-around and timeout.
// Build with MUX_ARB_TIMEOUT_EN defined (for both files) to exercise forced rotation.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_rr_arbiter_if #(.NREQ(8), .SEL_W(3)) bus ();

    mux_rr_arbiter #(
        .NREQ    (8),
        .SEL_W   (3),
        .MAX_HOLD(4),
        .HOLD_W  (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [7:0] reqVal);
        bus.req = reqVal;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] eGrant, input logic [2:0] eSel,
                               input logic eValid, input logic eSw, input logic eTo);
        logic [13:0] obs;
        logic [13:0] exp;
        obs = {bus.grant, bus.sel, bus.valid, bus.switch_pulse, bus.timeout_pulse};
        exp = {eGrant, eSel, eValid, eSw, eTo};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed grant=%h sel=%0d valid=%b sw=%b to=%b, expected grant=%h sel=%0d valid=%b sw=%b to=%b",
                   tag, bus.grant, bus.sel, bus.valid, bus.switch_pulse, bus.timeout_pulse,
                   eGrant, eSel, eValid, eSw, eTo);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        #12;
        checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h00);
            checkOutput($sformatf("idle_%0d", i), 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        end

        // Single requester: grant, hold, release.
        applyStimulus(8'h01);
        checkOutput("req0_grant", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h01);
            checkOutput($sformatf("req0_hold_%0d", i), 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(8'h00);
        checkOutput("req0_release", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a grant is active.
        applyStimulus(8'h01);
        checkOutput("pre_reset_grant", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        bus.req = 8'h00;
        #1;
        rst_n = 1'b1;
        applyStimulus(8'h00);
        checkOutput("post_reset_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // All requesting; each owner drops its bit right after its grant.
        applyStimulus(8'hFF);
        checkOutput("rr_first", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'hFF & ~(8'h01 << i));
            checkOutput($sformatf("rr_%0d", (i + 1) % 8), 8'h01 << ((i + 1) % 8),
                        3'((i + 1) % 8), 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(8'h00);
        checkOutput("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Owner 5 holds against requester 0, then wrap-around hands to 0.
        applyStimulus(8'h20);
        checkOutput("own5_grant", 8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h21);
        checkOutput("own5_hold_a", 8'h20, 3'd5, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h21);
        checkOutput("own5_hold_b", 8'h20, 3'd5, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h01);
        checkOutput("wrap_to0", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);

        // Owner 3 with 7 pending: no preemption, then 7 wins after release.
        applyStimulus(8'h08);
        checkOutput("own3_grant", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h88);
        checkOutput("own3_no_preempt", 8'h08, 3'd3, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h80);
        checkOutput("own7_after3", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h08);
        checkOutput("own3_after7", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h00);
        checkOutput("idle_sel_kept", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);

        // Two requesters held continuously; search starts at 4 so 0 wins first.
        applyStimulus(8'h03);
        checkOutput("hold_grant0", 8'h01, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h03);
            checkOutput($sformatf("hold0_%0d", i), 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(8'h03);
`ifdef MUX_ARB_TIMEOUT_EN
        checkOutput("timeout_rot", 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);
        applyStimulus(8'h03);
        checkOutput("timeout_after", 8'h02, 3'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00);
        checkOutput("timeout_idle", 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);
`else
        checkOutput("no_timeout_a", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h03);
            checkOutput($sformatf("no_timeout_%0d", i), 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(8'h00);
        checkOutput("final_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
